// File: rtl/cart_loader.sv
// Cartridge loader: streams one image slot out of SPI flash with a single READ burst,
// writes it word by word through a ready/ack memory port, then checks the trailing flags word.
module cart_loader #(
    parameter int          WORD_BYTES    = 2,
    parameter int          ADDR_W        = 17,
    parameter int          IMAGE_WORDS   = 65536,
    parameter logic [23:0] BASE_ADDR     = 24'h040000,
    parameter int          SLOT_SHIFT    = 18,
    parameter int          SETTLE_CYCLES = 255,
    parameter bit          AUTOLOAD      = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    reload,
    input  logic [3:0]              index,
    output logic                    busy,
    output logic                    cart_ready,
    output logic                    cart_error,
    output logic [31:0]             flags_out,
    output logic [15:0]             checksum,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    mem_we,
    input  logic                    mem_ack,
    output logic                    flash_csn,
    output logic                    flash_sck,
    output logic                    flash_mosi,
    input  logic                    flash_miso,
    output logic [2:0]              fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_WRITE, S_FLAGS, S_SETTLE, S_DONE, S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMAGE_WORDS - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(WORD_BYTES - 1);
    localparam logic [15:0]       SETTLE_END = 16'(SETTLE_CYCLES);

    state_t                  state, state_n;
    logic [3:0]              index_q;
    logic                    autoload_pending;
    logic [5:0]              cnt;
    logic [31:0]             cmd_sr;
    logic [6:0]              sh;
    logic [1:0]              byte_idx;
    logic [8*WORD_BYTES-1:0] word_sr, word_next;
    logic [ADDR_W-1:0]       word_cnt;
    logic [15:0]             settle_cnt;
    logic [7:0]              byte_now;
    logic [3:0]              slot;
    logic [23:0]             start_addr;
    logic                    start;

    // Every load, including the boot-time one, begins from the same start event.
    assign start      = reload || (state == S_IDLE && autoload_pending);
    assign slot       = reload ? index : index_q;
    assign start_addr = BASE_ADDR + (24'(slot) << SLOT_SHIFT);
    assign byte_now   = {sh, flash_miso};
    assign fsm_state  = state;

    always_comb begin
        word_next = word_sr;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (byte_idx == 2'(b)) word_next[b*8 +: 8] = byte_now;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (reload) begin
            state_n = S_CMD;
        end else begin
            case (state)
                S_IDLE:   if (autoload_pending) state_n = S_CMD;
                S_CMD:    if (cnt == 6'd63) state_n = S_DATA;
                S_DATA:   if (cnt[3:0] == 4'hF && byte_idx == LAST_BYTE) state_n = S_WRITE;
                S_WRITE:  if (mem_ack) state_n = (word_cnt == LAST_WORD) ? S_FLAGS : S_DATA;
                S_FLAGS:  if (cnt == 6'd63) state_n = S_SETTLE;
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_END) begin
                        if (flags_out[31:16] == checksum || flags_out[31:16] == 16'h0000)
                            state_n = S_DONE;
                        else
                            state_n = S_ERROR;
                    end
                end
                default:  state_n = state;
            endcase
        end
    end

    // SPI bit = low phase (MOSI valid) then high phase; MISO sampled as the high phase ends.
    always_comb begin
        busy       = 1'b0;
        cart_ready = 1'b0;
        cart_error = 1'b0;
        mem_we     = 1'b0;
        flash_csn  = 1'b1;
        flash_sck  = 1'b0;
        flash_mosi = 1'b0;
        case (state)
            S_CMD: begin
                busy       = 1'b1;
                flash_csn  = 1'b0;
                flash_sck  = cnt[0];
                flash_mosi = cmd_sr[31];
            end
            S_DATA, S_FLAGS: begin
                busy      = 1'b1;
                flash_csn = 1'b0;
                flash_sck = cnt[0];
            end
            S_WRITE: begin
                busy      = 1'b1;
                flash_csn = 1'b0;
                mem_we    = 1'b1;
            end
            S_SETTLE: busy       = 1'b1;
            S_DONE:   cart_ready = 1'b1;
            S_ERROR:  cart_error = 1'b1;
            default:  busy       = 1'b0;
        endcase
        if (reload) begin
            flash_csn  = 1'b1;
            flash_sck  = 1'b0;
            flash_mosi = 1'b0;
            mem_we     = 1'b0;
            cart_ready = 1'b0;
            cart_error = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index_q          <= '0;
            autoload_pending <= AUTOLOAD;
            cnt              <= '0;
            cmd_sr           <= '0;
            sh               <= '0;
            byte_idx         <= '0;
            word_sr          <= '0;
            word_cnt         <= '0;
            settle_cnt       <= '0;
            checksum         <= '0;
            flags_out        <= '0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
        end else if (start) begin
            if (reload) index_q <= index;
            autoload_pending <= 1'b0;
            cnt              <= '0;
            cmd_sr           <= {8'h03, start_addr};
            byte_idx         <= '0;
            word_cnt         <= '0;
            settle_cnt       <= '0;
            checksum         <= '0;
            flags_out        <= '0;
        end else begin
            case (state)
                S_CMD: begin
                    cnt <= cnt + 6'd1;
                    if (cnt[0]) cmd_sr <= {cmd_sr[30:0], 1'b0};
                end
                S_DATA: begin
                    cnt <= cnt + 6'd1;
                    if (cnt[0]) sh <= byte_now[6:0];
                    if (cnt[3:0] == 4'hF) begin
                        cnt      <= '0;
                        checksum <= checksum + 16'(byte_now);
                        word_sr  <= word_next;
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx  <= '0;
                            mem_wdata <= word_next;
                            mem_addr  <= word_cnt;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack && word_cnt != LAST_WORD) word_cnt <= word_cnt + ADDR_W'(1);
                end
                S_FLAGS: begin
                    cnt <= cnt + 6'd1;
                    if (cnt[0]) sh <= byte_now[6:0];
                    // Flags arrive little-endian and stay out of the checksum.
                    if (cnt[3:0] == 4'hF) flags_out <= {byte_now, flags_out[31:8]};
                end
                S_SETTLE: settle_cnt <= settle_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule
